// File: rtl/rock_sequencer.sv
// Ramped amplitude/frequency sequencer: frequency only moves while amplitude is
// at or below a safe level, every change is paced by a tick-driven dwell counter.
module rock_sequencer #(
    parameter int SAFE_AMP = 1,
    parameter int DWELL    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       req_valid,
    input  logic [2:0] req_amp,
    input  logic [2:0] req_freq,
    input  logic       fault_in,
    output logic       req_ready,
    output logic [2:0] amp,
    output logic [2:0] freq,
    output logic       busy,
    output logic       done,
    output logic       fault
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        AMP_DOWN  = 3'd1,
        FREQ_STEP = 3'd2,
        AMP_MOVE  = 3'd3,
        STOPPING  = 3'd4,
        HALTED    = 3'd5
    } state_t;

    localparam logic [2:0] SAFE_LVL   = 3'(SAFE_AMP);
    localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);

    state_t     state_r, state_s;
    logic [2:0] amp_r, amp_s;
    logic [2:0] freq_r, freq_s;
    logic [2:0] tgt_amp_r, tgt_amp_s;
    logic [2:0] tgt_freq_r, tgt_freq_s;
    logic [3:0] dwell_r, dwell_s;
    logic       done_r, done_s;
    logic       busy_r, fault_r;
    logic       step_s, ready_s, handshake_s;

    // Saturating one-unit move toward a target; never wraps the 3-bit range.
    function automatic logic [2:0] step_toward(input logic [2:0] cur, input logic [2:0] tgt);
        logic [2:0] res;
        if (cur < tgt) begin
            res = cur + 3'd1;
        end else if (cur > tgt) begin
            res = cur - 3'd1;
        end else begin
            res = cur;
        end
        return res;
    endfunction

    assign step_s      = tick && (dwell_r == DWELL_LAST);
    assign ready_s     = (state_r == IDLE) && !fault_in;
    assign handshake_s = req_valid && ready_s;

    assign req_ready = ready_s;
    assign amp       = amp_r;
    assign freq      = freq_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign fault     = fault_r;

    // Next-state and datapath: fault preempts everything except an ongoing stop.
    always_comb begin
        state_s    = state_r;
        amp_s      = amp_r;
        freq_s     = freq_r;
        tgt_amp_s  = tgt_amp_r;
        tgt_freq_s = tgt_freq_r;
        done_s     = 1'b0;
        if (fault_in && (state_r != HALTED) && (state_r != STOPPING)) begin
            state_s = STOPPING;
        end else begin
            case (state_r)
                IDLE: begin
                    if (handshake_s) begin
                        tgt_amp_s  = req_amp;
                        tgt_freq_s = req_freq;
                        if (req_freq == freq_r) begin
                            state_s = AMP_MOVE;
                        end else if (amp_r > SAFE_LVL) begin
                            state_s = AMP_DOWN;
                        end else begin
                            state_s = FREQ_STEP;
                        end
                    end else begin
                        state_s = IDLE;
                    end
                end
                AMP_DOWN: begin
                    if (amp_r <= SAFE_LVL) begin
                        state_s = FREQ_STEP;
                    end else if (step_s) begin
                        amp_s = amp_r - 3'd1;
                    end else begin
                        amp_s = amp_r;
                    end
                end
                FREQ_STEP: begin
                    if (freq_r == tgt_freq_r) begin
                        state_s = AMP_MOVE;
                    end else if (step_s) begin
                        freq_s = step_toward(freq_r, tgt_freq_r);
                    end else begin
                        freq_s = freq_r;
                    end
                end
                AMP_MOVE: begin
                    if (amp_r == tgt_amp_r) begin
                        done_s  = 1'b1;
                        state_s = IDLE;
                    end else if (step_s) begin
                        amp_s = step_toward(amp_r, tgt_amp_r);
                    end else begin
                        amp_s = amp_r;
                    end
                end
                STOPPING: begin
                    if (amp_r == 3'd0) begin
                        state_s = HALTED;
                    end else if (step_s) begin
                        amp_s = amp_r - 3'd1;
                    end else begin
                        amp_s = amp_r;
                    end
                end
                HALTED: begin
                    state_s = HALTED;
                    amp_s   = 3'd0;
                end
                default: begin
                    state_s = HALTED;
                    amp_s   = 3'd0;
                end
            endcase
        end
    end

    // Dwell pacing: any state change restarts the count so each phase gets full dwell.
    always_comb begin
        dwell_s = dwell_r;
        if (state_s != state_r) begin
            dwell_s = 4'd0;
        end else if (step_s) begin
            dwell_s = 4'd0;
        end else if (tick) begin
            dwell_s = dwell_r + 4'd1;
        end else begin
            dwell_s = dwell_r;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            amp_r      <= 3'd0;
            freq_r     <= 3'd0;
            tgt_amp_r  <= 3'd0;
            tgt_freq_r <= 3'd0;
            dwell_r    <= 4'd0;
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
            fault_r    <= 1'b0;
        end else begin
            state_r    <= state_s;
            amp_r      <= amp_s;
            freq_r     <= freq_s;
            tgt_amp_r  <= tgt_amp_s;
            tgt_freq_r <= tgt_freq_s;
            dwell_r    <= dwell_s;
            done_r     <= done_s;
            busy_r     <= (state_s != IDLE) && (state_s != HALTED);
            fault_r    <= (state_s == HALTED);
        end
    end

endmodule
